// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcode/state encodings and iteration count for the multiply/divide unit
package mdu_pkg;
   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } mdu_op_e;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } mdu_state_e;
   localparam int MDU_ITERS = 32;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration, shift-add multiply or restoring divide on unsigned magnitudes
module mdu_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] acc_i,
   input  logic [W-1:0] opnd_i,
   input  logic         in_bit_i,
   input  logic         div_i,
   output logic [W-1:0] acc_o,
   output logic         bit_o
);
   logic [W:0] sum, sh, diff;
   always_comb begin
      sum   = {1'b0, acc_i} + (in_bit_i ? {1'b0, opnd_i} : '0);
      sh    = {acc_i, in_bit_i};
      diff  = sh - {1'b0, opnd_i};
      acc_o = div_i ? (diff[W] ? sh[W-1:0] : diff[W-1:0]) : sum[W:1];
      bit_o = div_i ? ~diff[W] : sum[0];
   end
endmodule

// File: rtl/mdu.sv
// mdu: iterative MULT/DIV unit with architectural HI/LO registers
module mdu
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);
   mdu_state_e state_q, state_d;
   mdu_op_e op;
   logic [4:0] cnt_q, cnt_d;
   logic [XLEN-1:0] acc_q, acc_d, low_q, low_d, opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
   logic [XLEN-1:0] mag_a, mag_b, step_acc;
   logic [2*XLEN-1:0] prod;
   logic div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, done_q, done_d;
   logic sa, sb, step_bit;
   assign op     = mdu_op_e'(op_i);
   assign sa     = ~op_i[0] & a_i[XLEN-1];
   assign sb     = ~op_i[0] & b_i[XLEN-1];
   assign mag_a  = sa ? -a_i : a_i;
   assign mag_b  = sb ? -b_i : b_i;
   assign prod   = neg_lo_q ? -{acc_q, low_q} : {acc_q, low_q};
   assign busy_o = state_q != IDLE;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   mdu_step #(.W(XLEN)) u_step (
      .acc_i   (acc_q),
      .opnd_i  (opnd_q),
      .in_bit_i(div_q ? low_q[XLEN-1] : low_q[0]),
      .div_i   (div_q),
      .acc_o   (step_acc),
      .bit_o   (step_bit)
   );
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      low_d    = low_q;
      opnd_d   = opnd_q;
      div_d    = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && !op_i[2]) begin
               div_d    = op_i[1];
               acc_d    = '0;
               low_d    = op_i[1] ? mag_a : mag_b;
               opnd_d   = op_i[1] ? mag_b : mag_a;
               // zero divisor keeps the all-ones quotient unsigned and the dividend as remainder
               neg_lo_d = (sa ^ sb) & (~op_i[1] | (|b_i));
               neg_hi_d = sa;
               cnt_d    = 5'(MDU_ITERS - 1);
               state_d  = RUN;
            end else if (start_i && op == OP_MTHI) begin
               hi_d = a_i;
            end else if (start_i && op == OP_MTLO) begin
               lo_d = a_i;
            end
         end
         RUN: begin
            acc_d   = step_acc;
            low_d   = div_q ? {low_q[XLEN-2:0], step_bit} : {step_bit, low_q[XLEN-1:1]};
            cnt_d   = cnt_q - 5'd1;
            state_d = cnt_q == '0 ? FINISH : RUN;
         end
         FINISH: begin
            hi_d    = div_q ? (neg_hi_q ? -acc_q : acc_q) : prod[2*XLEN-1:XLEN];
            lo_d    = div_q ? (neg_lo_q ? -low_q : low_q) : prod[XLEN-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         low_q    <= '0;
         opnd_q   <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         low_q    <= low_d;
         opnd_q   <= opnd_d;
         div_q    <= div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and random scoreboard bench for the mdu multiply/divide unit
module tb_mdu;
   logic        clk_i = 1'b0;
   logic        reset_i, start_i, busy_o, done_o;
   logic [2:0]  op_i;
   logic [31:0] a_i, b_i, hi_o, lo_o;
   logic [63:0] sb_q[$];
   int checks = 0;
   int fails = 0;
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] e;
   } vec_t;
   vec_t vecs[8] = '{
      '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001},
      '{3'b000, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB},
      '{3'b000, 32'h80000000, 32'h80000000, 64'h40000000_00000000},
      '{3'b010, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD},
      '{3'b011, 32'h00000007, 32'h00000002, 64'h00000001_00000003},
      '{3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000},
      '{3'b011, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF},
      '{3'b010, 32'hFFFFFFF0, 32'h00000000, 64'hFFFFFFF0_FFFFFFFF}
   };

   always #5 clk_i = ~clk_i;

   mdu dut (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .start_i(start_i),
      .op_i   (op_i),
      .a_i    (a_i),
      .b_i    (b_i),
      .busy_o (busy_o),
      .done_o (done_o),
      .hi_o   (hi_o),
      .lo_o   (lo_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] xa, xb;
      int qa, qb;
      xa = 64'($signed(a));
      xb = 64'($signed(b));
      qa = $signed(a);
      qb = $signed(b);
      if (op == 3'b000) return xa * xb;
      if (op == 3'b001) return {32'd0, a} * {32'd0, b};
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (op == 3'b011) return {a % b, a / b};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
      return {32'(qa % qb), 32'(qa / qb)};
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
      sb_q.push_back(e);
      start_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic finish_op(input string tag, input int exp_busy);
      int n = 0;
      int busy_n = 0;
      logic [63:0] e;
      while (!done_o && n < 100) begin
         busy_n += int'(busy_o);
         @(negedge clk_i);
         n++;
      end
      chk({tag, "_done"}, 64'(done_o), 64'd1);
      chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
      chk({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
      chk({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
      e = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
      chk({tag, "_hilo"}, {hi_o, lo_o}, e);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int dn;
      reset_i = 1'b1;
      start_i = 1'b0;
      op_i    = '0;
      a_i     = '0;
      b_i     = '0;
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_hilo", {hi_o, lo_o}, 64'd0);
      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
         finish_op($sformatf("vec%0d", i), 33);
         @(negedge clk_i);
         chk($sformatf("vec%0d_pulse", i), 64'(done_o), 64'd0);
      end
      for (int i = 0; i < 6; i++) begin
         rop = 3'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i == 5) ? 32'd0 : $urandom;
         issue(rop, ra, rb, model(rop, ra, rb));
         finish_op($sformatf("rnd%0d", i), 33);
         @(negedge clk_i);
      end
      start_i = 1'b1;
      op_i    = 3'b101;
      a_i     = 32'h00001234;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("mtlo_lo", 64'(lo_o), 64'h1234);
      chk("mtlo_done", 64'(done_o), 64'd0);
      chk("mtlo_busy", 64'(busy_o), 64'd0);
      start_i = 1'b1;
      op_i    = 3'b100;
      a_i     = 32'h0000ABCD;
      @(negedge clk_i);
      op_i    = 3'b110;
      a_i     = 32'hDEADBEEF;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("reserved_hilo", {hi_o, lo_o}, {32'h0000ABCD, 32'h00001234});
      chk("reserved_busy", 64'(busy_o), 64'd0);
      issue(3'b000, 32'h00001234, 32'h00000010, 64'h00000000_00012340);
      repeat (3) @(negedge clk_i);
      start_i = 1'b1;
      op_i    = 3'b011;
      a_i     = 32'd100;
      b_i     = 32'd3;
      @(negedge clk_i);
      op_i    = 3'b100;
      a_i     = 32'hDEAD0000;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("hold_hilo", {hi_o, lo_o}, {32'h0000ABCD, 32'h00001234});
      finish_op("ignore", 28);
      issue(3'b001, 32'd3, 32'd5, 64'd15);
      finish_op("b2b_first", 33);
      issue(3'b011, 32'd100, 32'd7, {32'd2, 32'd14});
      chk("b2b_accept", 64'(busy_o), 64'd1);
      finish_op("b2b_second", 33);
      @(negedge clk_i);
      start_i = 1'b1;
      op_i    = 3'b011;
      a_i     = 32'd1000;
      b_i     = 32'd9;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (9) @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
      reset_i = 1'b0;
      dn = 0;
      repeat (40) begin
         @(negedge clk_i);
         dn += int'(done_o);
      end
      chk("midrst_no_done", 64'(dn), 64'd0);
      reset_i = 1'b1;
      start_i = 1'b1;
      op_i    = 3'b000;
      a_i     = 32'd3;
      b_i     = 32'd3;
      @(negedge clk_i);
      reset_i = 1'b0;
      start_i = 1'b0;
      chk("rst_prio_busy", 64'(busy_o), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
